// File: rtl/core_pkg.sv
// Shared widths, ALU opcodes and the ALU function for the EX stage and its register file.
package core_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_W    = 3;
  localparam int NUM_REGS = 1 << REG_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_t;

  localparam logic ALUOP_ADD = 1'b0;
  localparam logic ALUOP_SLL = 1'b1;
  localparam reg_t REG_ZERO  = '0;

  // SLL uses only the low three bits of B, so the shift never clears the whole word.
  function automatic data_t alu_eval(input logic op, input data_t a, input data_t b);
    data_t r;
    if (op == ALUOP_SLL) r = a << b[2:0];
    else                 r = a + b;
    return r;
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8x8 register file: one write port, two read ports plus a debug read, r0 hardwired to zero.
module regfile_8x8
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  reg_t  waddr,
  input  data_t wdata,
  input  reg_t  raddr1,
  input  reg_t  raddr2,
  input  reg_t  dbg_addr,
  output data_t rdata1,
  output data_t rdata2,
  output data_t dbg_data
);

  data_t rf_q [NUM_REGS];

  // Reset loads each register with its own index so reads are never X.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= DATA_W'(i);
    end else if (we && (waddr != REG_ZERO)) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == REG_ZERO) ? '0 : rf_q[raddr1];
  assign rdata2   = (raddr2   == REG_ZERO) ? '0 : rf_q[raddr2];
  assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : rf_q[dbg_addr];

endmodule

// File: rtl/ex_wb_regfile.sv
// EX-stage ALU, EX/WB pipeline register and write-back, with EX/WB forwarding to the ID read ports.
module ex_wb_regfile
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ID_EX_RegWrite,
  input  logic  ID_EX_ALUOp,
  input  data_t ID_EX_Data1,
  input  data_t ID_EX_Data2,
  input  reg_t  ID_EX_Reg,
  input  reg_t  ReadReg1,
  input  reg_t  ReadReg2,
  output data_t Data1,
  output data_t Data2,
  output logic  EX_WB_RegWrite,
  output data_t EX_WB_Result,
  output reg_t  EX_WB_Reg,
  input  reg_t  DbgRegNum,
  output data_t DbgData
);

  logic  wb_we_q;
  data_t wb_result_q, wb_result_d;
  reg_t  wb_reg_q;
  data_t rf_rd1, rf_rd2;

  assign wb_result_d = alu_eval(ID_EX_ALUOp, ID_EX_Data1, ID_EX_Data2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_we_q     <= 1'b0;
      wb_result_q <= '0;
      wb_reg_q    <= REG_ZERO;
    end else begin
      wb_we_q     <= ID_EX_RegWrite;
      wb_result_q <= wb_result_d;
      wb_reg_q    <= ID_EX_Reg;
    end
  end

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we_q),
    .waddr    (wb_reg_q),
    .wdata    (wb_result_q),
    .raddr1   (ReadReg1),
    .raddr2   (ReadReg2),
    .dbg_addr (DbgRegNum),
    .rdata1   (rf_rd1),
    .rdata2   (rf_rd2),
    .dbg_data (DbgData)
  );

  // The younger EX result wins over the older EX/WB result for the same register.
  function automatic data_t fwd(input reg_t rs, input data_t rf_val);
    data_t r;
    if (rs == REG_ZERO)                            r = '0;
    else if (ID_EX_RegWrite && (ID_EX_Reg == rs))  r = wb_result_d;
    else if (wb_we_q && (wb_reg_q == rs))          r = wb_result_q;
    else                                           r = rf_val;
    return r;
  endfunction

  assign Data1 = fwd(ReadReg1, rf_rd1);
  assign Data2 = fwd(ReadReg2, rf_rd2);

  assign EX_WB_RegWrite = wb_we_q;
  assign EX_WB_Result   = wb_result_q;
  assign EX_WB_Reg      = wb_reg_q;

endmodule

// File: tb/tb_ex_wb_regfile.sv
// Self-checking bench for ex_wb_regfile: directed scenarios, then random traffic against a reference model.
module tb_ex_wb_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_we, id_op;
  logic [7:0] id_a, id_b;
  logic [2:0] id_rd, rr1, rr2, dbg_num;
  logic [7:0] d1, d2, ex_wb_res, dbg_data;
  logic       ex_wb_we;
  logic [2:0] ex_wb_reg;

  int checks = 0;
  int errors = 0;

  // reference state: architectural registers and the one pending write-back
  int m_rf [8];
  int m_wb_we, m_wb_res, m_wb_reg;

  always #5 clk = ~clk;

  ex_wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .ID_EX_RegWrite (id_we),
    .ID_EX_ALUOp    (id_op),
    .ID_EX_Data1    (id_a),
    .ID_EX_Data2    (id_b),
    .ID_EX_Reg      (id_rd),
    .ReadReg1       (rr1),
    .ReadReg2       (rr2),
    .Data1          (d1),
    .Data2          (d2),
    .EX_WB_RegWrite (ex_wb_we),
    .EX_WB_Result   (ex_wb_res),
    .EX_WB_Reg      (ex_wb_reg),
    .DbgRegNum      (dbg_num),
    .DbgData        (dbg_data)
  );

  function automatic int ref_alu(int op, int a, int b);
    if (op == 1) return (a * (2 ** (b % 8))) % 256;
    return (a + b) % 256;
  endfunction

  function automatic int ref_read(int rs);
    if (rs == 0) return 0;
    if (id_we && int'(id_rd) == rs) return ref_alu(int'(id_op), int'(id_a), int'(id_b));
    if (m_wb_we != 0 && m_wb_reg == rs) return m_wb_res;
    return m_rf[rs];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs in the low phase, then compare every output against the model.
  task automatic drive(input logic rstv, input logic we, input logic op, input int a, input int b,
                       input int rd, input int r1, input int r2, input int dbg, input bit do_chk);
    @(negedge clk);
    rst = rstv; id_we = we; id_op = op; id_a = 8'(a); id_b = 8'(b);
    id_rd = 3'(rd); rr1 = 3'(r1); rr2 = 3'(r2); dbg_num = 3'(dbg);
    #1;
    if (do_chk) begin
      chk("data1", int'(d1), ref_read(r1));
      chk("data2", int'(d2), ref_read(r2));
      chk("dbg", int'(dbg_data), (dbg == 0) ? 0 : m_rf[dbg]);
      chk("wb_we", int'(ex_wb_we), m_wb_we);
      chk("wb_res", int'(ex_wb_res), m_wb_res);
      chk("wb_reg", int'(ex_wb_reg), m_wb_reg);
    end
  endtask

  task automatic tick();
    int nres;
    @(posedge clk);
    nres = ref_alu(int'(id_op), int'(id_a), int'(id_b));
    if (rst == 1'b0) begin
      for (int i = 0; i < 8; i++) m_rf[i] = i;
      m_wb_we = 0; m_wb_res = 0; m_wb_reg = 0;
    end else begin
      if (m_wb_we != 0 && m_wb_reg != 0) m_rf[m_wb_reg] = m_wb_res;
      m_wb_we = int'(id_we); m_wb_res = nres; m_wb_reg = int'(id_rd);
    end
  endtask

  initial begin
    rst = 1'b0; id_we = 0; id_op = 0; id_a = 0; id_b = 0;
    id_rd = 0; rr1 = 0; rr2 = 0; dbg_num = 0;

    // reset, then idle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 7, 0, 3, 1);
    chk("rst_dbg_r3", int'(dbg_data), 8'h03);
    chk("rst_r7", int'(d1), 8'h07);
    chk("rst_r0", int'(d2), 8'h00);
    chk("rst_wb_res", int'(ex_wb_res), 0);
    tick();

    // ADD 3+4 -> r5 followed through EX forward, WB forward and rf
    drive(1, 1, 0, 8'h03, 8'h04, 5, 5, 5, 5, 1);
    chk("ex_fwd", int'(d1), 8'h07); tick();
    drive(1, 0, 0, 0, 0, 0, 5, 0, 5, 1);
    chk("wb_fwd", int'(d1), 8'h07); chk("wb_result", int'(ex_wb_res), 8'h07); tick();
    drive(1, 0, 0, 0, 0, 0, 5, 0, 5, 1);
    chk("rf_r5", int'(d1), 8'h07); chk("dbg_r5", int'(dbg_data), 8'h07); tick();

    // ADD wrap and SLL ignoring upper shift bits
    drive(1, 1, 0, 8'hF0, 8'h20, 2, 2, 0, 0, 1);
    chk("add_wrap", int'(d1), 8'h10); tick();
    drive(1, 1, 1, 8'h81, 8'h0A, 3, 3, 2, 0, 1);
    chk("sll", int'(d1), 8'h04); tick();

    // back-to-back writes to r6
    drive(1, 1, 0, 1, 1, 6, 6, 6, 6, 1); tick();
    drive(1, 1, 0, 5, 5, 6, 0, 6, 6, 1);
    chk("ex_beats_wb", int'(d2), 8'h0A); tick();
    drive(1, 0, 0, 0, 0, 0, 6, 6, 6, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 6, 6, 6, 1);
    chk("final_r6", int'(dbg_data), 8'h0A); tick();

    // writes to r0 never become visible
    drive(1, 1, 0, 8'h50, 8'h05, 0, 0, 0, 0, 1); chk("r0_c0", int'(d1), 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("r0_c1", int'(d1), 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("r0_c2", int'(d1), 0); chk("dbg_r0", int'(dbg_data), 0); tick();

    // reset while a write-back of 0x99 to r5 is pending
    drive(1, 1, 0, 8'h99, 8'h00, 5, 0, 0, 5, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0, 5, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 5, 0, 5, 1);
    chk("rst_drop_r5", int'(dbg_data), 8'h05); chk("rst_drop_we", int'(ex_wb_we), 0);
    chk("rst_drop_reg", int'(ex_wb_reg), 0);
    tick();

    // reset pulse between edges alone leaves state untouched
    drive(1, 1, 0, 8'h11, 8'h22, 4, 0, 0, 0, 1);
    rst = 1'b0; #1; rst = 1'b1; #1;
    tick();
    drive(1, 0, 0, 0, 0, 0, 4, 0, 4, 1);
    chk("glitch_wb", int'(ex_wb_res), 8'h33); tick();
    drive(1, 0, 0, 0, 0, 0, 4, 0, 4, 1);
    chk("glitch_rf", int'(dbg_data), 8'h33); tick();

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
